binary_to_bcd_seq: RTL and testbench

Sequential double-dabble converter that turns an unsigned binary value into packed BCD digits. It sits directly upstream of the per-digit 7-segment encoders: each 4-bit BCD nibble of o_BCD drives one encoder's 4-bit binary input. It uses a start/busy/data-valid handshake so that counters and measurement blocks can request a decimal display update.

---
 rtl/binary_to_bcd_seq.sv | 119 +++++++++++
 tb/tb_binary_to_bcd_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned binary in, packed BCD digits out,
// with a start/busy/data-valid handshake for display update requests.
module binary_to_bcd_seq #(
    parameter int unsigned INPUT_WIDTH    = 8,
    parameter int unsigned DECIMAL_DIGITS = 3
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic [INPUT_WIDTH-1:0]        i_Binary,
    input  logic                          i_Start,
    output logic [DECIMAL_DIGITS*4-1:0]   o_BCD,
    output logic                          o_DV,
    output logic                          o_Busy,
    output logic                          o_Overflow
);

    localparam int unsigned BCD_W = DECIMAL_DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(INPUT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ADD3,
        DONE
    } state_t;

    state_t                 state, state_next;
    logic [BCD_W-1:0]       scratch, scratch_next;
    logic [INPUT_WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]       count, count_next;
    logic                   sticky, sticky_next;
    logic [BCD_W-1:0]       bcd_next;
    logic                   dv_next;
    logic                   busy_next;
    logic                   ovf_next;

    // State and datapath registers; reset wins over everything, aborting any conversion.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= IDLE;
            scratch    <= '0;
            shift_reg  <= '0;
            count      <= '0;
            sticky     <= 1'b0;
            o_BCD      <= '0;
            o_DV       <= 1'b0;
            o_Busy     <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            state      <= state_next;
            scratch    <= scratch_next;
            shift_reg  <= shift_next;
            count      <= count_next;
            sticky     <= sticky_next;
            o_BCD      <= bcd_next;
            o_DV       <= dv_next;
            o_Busy     <= busy_next;
            o_Overflow <= ovf_next;
        end
    end

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_next   = state;
        scratch_next = scratch;
        shift_next   = shift_reg;
        count_next   = count;
        sticky_next  = sticky;
        bcd_next     = o_BCD;
        ovf_next     = o_Overflow;
        dv_next      = 1'b0;

        case (state)
            IDLE: begin
                if (i_Start) begin
                    shift_next   = i_Binary;
                    scratch_next = '0;
                    sticky_next  = 1'b0;
                    count_next   = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_next, shift_next} = {scratch, shift_reg} << 1;
                // A bit leaving the top digit means a discarded higher decimal digit.
                if (scratch[BCD_W-1]) begin
                    sticky_next = 1'b1;
                end
                count_next = count + CNT_W'(1);
                if (count_next == CNT_W'(INPUT_WIDTH)) begin
                    state_next = DONE;
                end else begin
                    state_next = ADD3;
                end
            end
            ADD3: begin
                for (int unsigned d = 0; d < DECIMAL_DIGITS; d++) begin
                    if (scratch[4*d +: 4] >= 4'd5) begin
                        scratch_next[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
                    end
                end
                state_next = SHIFT;
            end
            DONE: begin
                bcd_next   = scratch;
                ovf_next   = sticky;
                dv_next    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Busy tracks the registered state so it drops in the same cycle o_DV rises.
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed self-checking bench for binary_to_bcd_seq: default, 2-digit and
// 4-bit/2-digit configurations exercised from one linear stimulus sequence.
module tb_binary_to_bcd_seq;

    logic clk = 1'b0;
    logic rst;

    logic [7:0]  bin0;
    logic        start0;
    logic [11:0] bcd0;
    logic        dv0, busy0, ovf0;

    logic [7:0]  bin1;
    logic        start1;
    logic [7:0]  bcd1;
    logic        dv1, busy1, ovf1;

    logic [3:0]  bin2;
    logic        start2;
    logic [7:0]  bcd2;
    logic        dv2, busy2, ovf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    binary_to_bcd_seq #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(3)) u0 (
        .i_Clk(clk), .i_Rst(rst), .i_Binary(bin0), .i_Start(start0),
        .o_BCD(bcd0), .o_DV(dv0), .o_Busy(busy0), .o_Overflow(ovf0)
    );

    binary_to_bcd_seq #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(2)) u1 (
        .i_Clk(clk), .i_Rst(rst), .i_Binary(bin1), .i_Start(start1),
        .o_BCD(bcd1), .o_DV(dv1), .o_Busy(busy1), .o_Overflow(ovf1)
    );

    binary_to_bcd_seq #(.INPUT_WIDTH(4), .DECIMAL_DIGITS(2)) u2 (
        .i_Clk(clk), .i_Rst(rst), .i_Binary(bin2), .i_Start(start2),
        .o_BCD(bcd2), .o_DV(dv2), .o_Busy(busy2), .o_Overflow(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic dv_of(input int sel);
        case (sel)
            0:       return dv0;
            1:       return dv1;
            default: return dv2;
        endcase
    endfunction

    // Steps until the selected instance pulses o_DV; n = edges advanced.
    task automatic wait_dv(input int sel, output int n);
        n = 0;
        while (!dv_of(sel) && n < 40) begin
            step();
            n++;
        end
        chk("dv_seen", 32'(dv_of(sel)), 32'd1);
    endtask

    // Decimal reference by repeated division.
    function automatic logic [31:0] dec(input int unsigned v, input int unsigned digits);
        logic [31:0] r;
        r = '0;
        for (int unsigned d = 0; d < digits; d++) begin
            r = r | (32'(v % 10) << (4 * d));
            v = v / 10;
        end
        return r;
    endfunction

    initial begin
        int n;
        int dv_count;

        rst = 1'b1;
        bin0 = '0; start0 = 1'b0;
        bin1 = '0; start1 = 1'b0;
        bin2 = '0; start2 = 1'b0;
        step();
        step();
        chk("rst_bcd",  32'(bcd0),  32'h0);
        chk("rst_dv",   32'(dv0),   32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_ovf",  32'(ovf0),  32'h0);
        rst = 1'b0;

        // Zero conversion with exact latency and busy window.
        bin0 = 8'd0; start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk("lat_busy", 32'(busy0), 32'h1);
            chk("lat_nodv", 32'(dv0),   32'h0);
            step();
        end
        chk("zero_dv",   32'(dv0),   32'h1);
        chk("zero_busy", 32'(busy0), 32'h0);
        chk("zero_bcd",  32'(bcd0),  32'h000);
        chk("zero_ovf",  32'(ovf0),  32'h0);
        step();
        chk("zero_dv_pulse", 32'(dv0), 32'h0);

        // Back-to-back sweep 0..255, restarting in each o_DV cycle.
        bin0 = 8'd0; start0 = 1'b1;
        step();
        for (int v = 0; v < 256; v++) begin
            wait_dv(0, n);
            chk("sweep_lat", 32'(n), 32'd16);
            chk("sweep_bcd", 32'(bcd0), dec(v, 3));
            chk("sweep_ovf", 32'(ovf0), 32'h0);
            if (v == 255) chk("hand_255", 32'(bcd0), 32'h255);
            if (v == 99)  chk("hand_099", 32'(bcd0), 32'h099);
            if (v == 128) chk("hand_128", 32'(bcd0), 32'h128);
            bin0 = 8'(v + 1);
            start0 = (v != 255);
            step();
        end
        start0 = 1'b0;

        // Start while busy is ignored.
        bin0 = 8'd200; start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int c = 0; c < 4; c++) step();
        bin0 = 8'd7; start0 = 1'b1;
        step();
        start0 = 1'b0;
        wait_dv(0, n);
        chk("ign_lat", 32'(n), 32'd11);
        chk("ign_bcd", 32'(bcd0), 32'h200);
        dv_count = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (dv0) dv_count++;
        end
        chk("ign_no_second_dv", 32'(dv_count), 32'd0);

        // Reset mid-conversion aborts it.
        bin0 = 8'd173; start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int c = 0; c < 5; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_bcd",  32'(bcd0),  32'h0);
        chk("abort_busy", 32'(busy0), 32'h0);
        chk("abort_dv",   32'(dv0),   32'h0);
        dv_count = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (dv0) dv_count++;
        end
        chk("abort_no_dv", 32'(dv_count), 32'd0);
        bin0 = 8'd42; start0 = 1'b1;
        step();
        start0 = 1'b0;
        wait_dv(0, n);
        chk("after_abort_lat", 32'(n), 32'd16);
        chk("after_abort_bcd", 32'(bcd0), 32'h042);

        // Two-digit overflow cases.
        bin1 = 8'd173; start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_dv(1, n);
        chk("d2_173_bcd", 32'(bcd1), 32'h73);
        chk("d2_173_ovf", 32'(ovf1), 32'h1);
        step();
        chk("d2_hold_bcd", 32'(bcd1), 32'h73);
        chk("d2_hold_ovf", 32'(ovf1), 32'h1);
        bin1 = 8'd99; start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_dv(1, n);
        chk("d2_99_bcd", 32'(bcd1), 32'h99);
        chk("d2_99_ovf", 32'(ovf1), 32'h0);
        bin1 = 8'd100; start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_dv(1, n);
        chk("d2_100_bcd", 32'(bcd1), 32'h00);
        chk("d2_100_ovf", 32'(ovf1), 32'h1);

        // Four-bit input, start held high: one conversion every 9 cycles.
        bin2 = 4'd15; start2 = 1'b1;
        step();
        wait_dv(2, n);
        chk("w4_lat", 32'(n), 32'd8);
        chk("w4_bcd", 32'(bcd2), 32'h15);
        chk("w4_ovf", 32'(ovf2), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("w4_dv_pulse", 32'(dv2), 32'h0);
            chk("w4_busy_again", 32'(busy2), 32'h1);
            wait_dv(2, n);
            chk("w4_period", 32'(n), 32'd8);
            chk("w4_bcd_rep", 32'(bcd2), 32'h15);
        end
        start2 = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
